// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: op-code encoding and shared constants for the bitwise logic unit.
package logic_unit_pkg;

    // Width of the operation select field
    localparam int LU_OP_W = 3;

    // Operation encoding; all eight codes are legal
    typedef enum logic [LU_OP_W-1:0] {
        LU_AND    = 3'd0,
        LU_OR     = 3'd1,
        LU_XOR    = 3'd2,
        LU_NOR    = 3'd3,
        LU_NAND   = 3'd4,
        LU_XNOR   = 3'd5,
        LU_ANDN   = 3'd6,   // a & ~b
        LU_PASS_A = 3'd7
    } lu_op_e;

endpackage

// File: rtl/logic_unit_core.sv
// logic_unit_core: combinational op decode plus zero/all-ones/parity flags.
// No state; the enclosing pipeline registers everything it produces.
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  lu_op_e           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             ones,
    output logic             parity
);

    logic [WIDTH-1:0] w_y;

    // Select the bitwise result for the current op
    always_comb begin
        w_y = a;
        case (op)
            LU_AND:    w_y = a & b;
            LU_OR:     w_y = a | b;
            LU_XOR:    w_y = a ^ b;
            LU_NOR:    w_y = ~(a | b);
            LU_NAND:   w_y = ~(a & b);
            LU_XNOR:   w_y = ~(a ^ b);
            LU_ANDN:   w_y = a & ~b;
            LU_PASS_A: w_y = a;
            default:   w_y = a;
        endcase
    end

    assign y      = w_y;
    assign zero   = ~|w_y;
    assign ones   = &w_y;
    assign parity = ^w_y;

endmodule

// File: rtl/logic_unit.sv
// logic_unit: two-stage valid/ready pipelined bitwise logic unit.
// S1 captures operands on the input handshake; S2 computes the op and
// registers the result with its flags. in_ready looks through S2's
// readiness so a full S1 can still accept when S2 drains the same cycle.
// Optional completed-result counter enabled by defining LOGIC_UNIT_STATS_EN.
module logic_unit
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
`ifdef LOGIC_UNIT_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   y,
    output logic               zero,
    output logic               ones,
    output logic               parity
`ifdef LOGIC_UNIT_STATS_EN
    ,
    output logic [CNT_W-1:0]   op_count
`endif
);

    // Stage 1 operand registers
    logic             r_s1_valid;
    lu_op_e           r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;

    // Stage 2 result registers
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_y;
    logic             r_zero;
    logic             r_ones;
    logic             r_parity;

    // Handshake / transfer strobes
    logic             w_s1_load;
    logic             w_s2_load;
    logic             w_out_hs;

    // Core outputs computed from S1 contents
    logic [WIDTH-1:0] w_y;
    logic             w_zero;
    logic             w_ones;
    logic             w_parity;

    assign w_s2_load = r_s1_valid && (!r_s2_valid || out_ready);
    assign in_ready  = !r_s1_valid || w_s2_load;
    assign w_s1_load = in_valid && in_ready;
    assign w_out_hs  = r_s2_valid && out_ready;

    logic_unit_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op     (r_s1_op),
        .a      (r_s1_a),
        .b      (r_s1_b),
        .y      (w_y),
        .zero   (w_zero),
        .ones   (w_ones),
        .parity (w_parity)
    );

    // Stage 1: capture operands on input handshake, empty when drained into S2
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= LU_AND;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else begin
            if (w_s1_load) begin
                r_s1_valid <= 1'b1;
                r_s1_op    <= lu_op_e'(op);
                r_s1_a     <= a;
                r_s1_b     <= b;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2: register result and flags together; hold while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_y        <= '0;
            r_zero     <= 1'b0;
            r_ones     <= 1'b0;
            r_parity   <= 1'b0;
        end else begin
            if (w_s2_load) begin
                r_s2_valid <= 1'b1;
                r_y        <= w_y;
                r_zero     <= w_zero;
                r_ones     <= w_ones;
                r_parity   <= w_parity;
            end else if (w_out_hs) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign y         = r_y;
    assign zero      = r_zero;
    assign ones      = r_ones;
    assign parity    = r_parity;

`ifdef LOGIC_UNIT_STATS_EN
    logic [CNT_W-1:0] r_op_count;

    // Count output handshakes, sticking at the maximum value
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_count <= '0;
        end else if (w_out_hs && (r_op_count != {CNT_W{1'b1}})) begin
            r_op_count <= r_op_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign op_count = r_op_count;
`endif

endmodule

// File: tb/tb_logic_unit.sv
// tb_logic_unit: table-driven bench with an in-order scoreboard for logic_unit.
// Build with LOGIC_UNIT_STATS_EN defined to also exercise op_count (CNT_W=2).
module tb_logic_unit;

    localparam int WIDTH = 8;
`ifdef LOGIC_UNIT_STATS_EN
    localparam int CNT_W = 2;
`endif

    typedef struct {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] y;
        logic             z;
        logic             o;
        logic             p;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       op = 3'd0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             ones;
    logic             parity;
`ifdef LOGIC_UNIT_STATS_EN
    logic [CNT_W-1:0] op_count;
`endif

    int   n_chk  = 0;
    int   n_fail = 0;
    vec_t sb_q[$];
    vec_t tbl[12];
    vec_t bp[3];

    always #5 clk = ~clk;

    logic_unit #(
        .WIDTH (WIDTH)
`ifdef LOGIC_UNIT_STATS_EN
        ,
        .CNT_W (CNT_W)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zero      (zero),
        .ones      (ones),
        .parity    (parity)
`ifdef LOGIC_UNIT_STATS_EN
        ,
        .op_count  (op_count)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", nm, got, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s timeout @%0t", nm, $time);
    endtask

    // Offer one beat; returns just after the accepting edge
    task automatic send(input vec_t v);
        int n;
        @(negedge clk);
        in_valid = 1'b1; op = v.op; a = v.a; b = v.b;
        #1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk); #1; n++;
        end
        if (!in_ready) begin
            timeout("send");
            in_valid = 1'b0;
            return;
        end
        sb_q.push_back(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk); n++;
        end
        if (sb_q.size() != 0) timeout("drain");
    endtask

    // Scoreboard monitor: every output handshake must match the oldest expected beat
    initial begin
        vec_t e;
        forever begin
            @(negedge clk); #2;
            if (!rst && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_out", 32'(y), 32'hDEAD);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_y", 32'(y), 32'(e.y));
                    chk("sb_flags", {29'd0, zero, ones, parity}, {29'd0, e.z, e.o, e.p});
                end
            end
        end
    end

    initial begin
        int acc;
        int n;
        logic [WIDTH-1:0] y_hold;
        tbl[0]  = '{3'd1, 8'hAA, 8'hAA, 8'hAA, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{3'd1, 8'hC8, 8'h89, 8'hC9, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{3'd0, 8'hC8, 8'h89, 8'h88, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{3'd2, 8'hC8, 8'h89, 8'h41, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{3'd3, 8'hAA, 8'h55, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{3'd4, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{3'd7, 8'h07, 8'hF0, 8'h07, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{3'd5, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{3'd6, 8'hF0, 8'h3C, 8'hC0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{3'd5, 8'h3C, 8'h35, 8'hF6, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{3'd6, 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{3'd0, 8'h01, 8'h01, 8'h01, 1'b0, 1'b0, 1'b1};
        bp[0]   = '{3'd1, 8'h12, 8'h30, 8'h32, 1'b0, 1'b0, 1'b1};
        bp[1]   = '{3'd2, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0};
        bp[2]   = '{3'd7, 8'h80, 8'h00, 8'h80, 1'b0, 1'b0, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_flags", {29'd0, zero, ones, parity}, 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        @(negedge clk); rst = 1'b0;

        // Latency: nothing after the accepting edge, result one edge later
        send(tbl[0]);
        chk("lat_empty", 32'(out_valid), 0);
        @(posedge clk); #1;
        chk("lat_valid", 32'(out_valid), 1);
        chk("lat_y", 32'(y), 32'hAA);
        drain();

        // Table: back-to-back beats at full throughput
        for (int i = 0; i < 12; i++) send(tbl[i]);
        drain();

        // Back-pressure: 4 stalled cycles while offering 3 beats
        @(negedge clk);
        out_ready = 1'b0;
        acc = 0;
        y_hold = '0;
        for (int c = 0; c < 4; c++) begin
            if (c != 0) @(negedge clk);
            in_valid = 1'b1; op = bp[acc].op; a = bp[acc].a; b = bp[acc].b;
            #1;
            if (c == 2) y_hold = y;
            if (c == 3) chk("bp_y_stable", 32'(y), 32'(y_hold));
            if (in_ready) begin
                sb_q.push_back(bp[acc]);
                acc++;
            end
        end
        chk("bp_accepted", acc, 2);
        chk("bp_in_ready", 32'(in_ready), 0);
        chk("bp_out_valid", 32'(out_valid), 1);
        chk("bp_y_first", 32'(y), 32'(bp[0].y));
        @(negedge clk);
        out_ready = 1'b1;
        op = bp[2].op; a = bp[2].a; b = bp[2].b;
        #1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk); #1; n++;
        end
        if (!in_ready) timeout("bp_third");
        else sb_q.push_back(bp[2]);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // Reset with both stages full discards in-flight beats
        @(negedge clk);
        out_ready = 1'b0;
        send(tbl[1]);
        send(tbl[3]);
        @(negedge clk);
        chk("full_out_valid", 32'(out_valid), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        sb_q.delete();
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_y", 32'(y), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        send(tbl[5]);
        chk("post_rst_empty", 32'(out_valid), 0);
        @(posedge clk); #1;
        chk("post_rst_valid", 32'(out_valid), 1);
        chk("post_rst_y", 32'(y), 32'hFF);
        drain();

`ifdef LOGIC_UNIT_STATS_EN
        // Saturating counter with CNT_W=2
        begin
            int cexp[5];
            cexp = '{1, 2, 3, 3, 3};
            @(negedge clk); rst = 1'b1;
            @(posedge clk); #1;
            chk("cnt_rst", 32'(op_count), 0);
            @(negedge clk); rst = 1'b0;
            for (int k = 0; k < 5; k++) begin
                send(tbl[k + 2]);
                n = 0;
                @(negedge clk); #1;
                while (!out_valid && n < 100) begin
                    @(negedge clk); #1; n++;
                end
                if (!out_valid) timeout("cnt_wait");
                @(posedge clk); #1;
                chk("op_count", 32'(op_count), 32'(cexp[k]));
            end
            drain();
        end
`endif

        repeat (2) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
